tpu_layer_sequencer: RTL and testbench

- Multi-layer scheduler sitting above the top-level TPU control FSM.
- Holds a small table of per-layer configurations written by the CFG block.
- For each layer in turn: drives the enables and base addresses, runs the start_tpu/done_tpu handshake with the control FSM, then moves to the next layer.
- Lets the host launch a whole network of up to MAX_LAYERS layers with one request instead of one request per layer.

---
 rtl/tpu_layer_sequencer_if.sv | 37 +++
 rtl/tpu_layer_sequencer.sv | 127 ++++++++++++
 tb/tb_tpu_layer_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/tpu_layer_sequencer_if.sv
// Host/CFG/control-FSM side signals of the layer sequencer.
// slave = the sequencer, master = whoever drives the sequence (host + control FSM).
interface tpu_layer_sequencer_if #(
  parameter int IDX_W  = 3,
  parameter int ADDR_W = 10
);
  logic                    seq_start;
  logic [IDX_W:0]          num_layers;
  logic                    cfg_wr_en;
  logic [IDX_W-1:0]        cfg_wr_idx;
  logic [3+3*ADDR_W-1:0]   cfg_wr_data;
  logic                    done_tpu;
  logic                    start_tpu;
  logic                    enable_matmul;
  logic                    enable_norm;
  logic                    enable_pool;
  logic                    enable_activation;
  logic [ADDR_W-1:0]       addr_a;
  logic [ADDR_W-1:0]       addr_b;
  logic [ADDR_W-1:0]       addr_c;
  logic [IDX_W-1:0]        layer_idx;
  logic                    seq_busy;
  logic                    seq_done;
  logic                    seq_error;

  modport slave (
    input  seq_start, num_layers, cfg_wr_en, cfg_wr_idx, cfg_wr_data, done_tpu,
    output start_tpu, enable_matmul, enable_norm, enable_pool, enable_activation,
           addr_a, addr_b, addr_c, layer_idx, seq_busy, seq_done, seq_error
  );

  modport master (
    output seq_start, num_layers, cfg_wr_en, cfg_wr_idx, cfg_wr_data, done_tpu,
    input  start_tpu, enable_matmul, enable_norm, enable_pool, enable_activation,
           addr_a, addr_b, addr_c, layer_idx, seq_busy, seq_done, seq_error
  );
endinterface

// File: rtl/tpu_layer_sequencer.sv
// Runs up to MAX_LAYERS table-configured layers through the start_tpu/done_tpu handshake.
// Optional RUN-state watchdog enabled by defining SEQ_WATCHDOG_EN.
module tpu_layer_sequencer #(
  parameter int MAX_LAYERS = 8,
  parameter int IDX_W      = 3,
  parameter int ADDR_W     = 10
`ifdef SEQ_WATCHDOG_EN
  , parameter int TIMEOUT_W = 16
`endif
) (
  input  logic                clk,
  input  logic                reset,
  tpu_layer_sequencer_if.slave bus
);
  localparam int ENTRY_W = 3 + 3*ADDR_W;
  localparam logic [IDX_W:0] MAX_N = (IDX_W+1)'(MAX_LAYERS);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE, S_ERR} state_t;

  state_t             state;
  logic [IDX_W:0]     n_lat;
  logic [ENTRY_W-1:0] tbl [MAX_LAYERS];

`ifdef SEQ_WATCHDOG_EN
  // Timeout fires on the RUN cycle whose increment would reach all-ones.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [TIMEOUT_W-1:0] wd_cnt;
`endif

  // Table is deliberately not reset; writes only land while no layer is in flight.
  always_ff @(posedge clk) begin
    if (bus.cfg_wr_en && (state == S_IDLE || state == S_DONE || state == S_ERR))
      tbl[bus.cfg_wr_idx] <= bus.cfg_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                 <= S_IDLE;
      n_lat                 <= '0;
      bus.start_tpu         <= 1'b0;
      bus.enable_matmul     <= 1'b0;
      bus.enable_norm       <= 1'b0;
      bus.enable_pool       <= 1'b0;
      bus.enable_activation <= 1'b0;
      bus.addr_a            <= '0;
      bus.addr_b            <= '0;
      bus.addr_c            <= '0;
      bus.layer_idx         <= '0;
      bus.seq_busy          <= 1'b0;
      bus.seq_done          <= 1'b0;
      bus.seq_error         <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wd_cnt                <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (bus.seq_start) begin
          n_lat <= bus.num_layers;
          if (bus.num_layers == '0) begin
            bus.seq_done <= 1'b1;
            state        <= S_DONE;
          end else if (bus.num_layers > MAX_N) begin
            bus.seq_error <= 1'b1;
            state         <= S_ERR;
          end else begin
            bus.layer_idx <= '0;
            bus.seq_busy  <= 1'b1;
            state         <= S_LOAD;
          end
        end
        S_LOAD: begin
          {bus.enable_norm, bus.enable_pool, bus.enable_activation,
           bus.addr_a, bus.addr_b, bus.addr_c} <= tbl[bus.layer_idx];
          bus.enable_matmul <= 1'b1;
`ifdef SEQ_WATCHDOG_EN
          wd_cnt            <= '0;
`endif
          state             <= S_RUN;
        end
        S_RUN: begin
          if (bus.done_tpu) begin
            bus.start_tpu <= 1'b0;
            state         <= S_DRAIN;
          end
`ifdef SEQ_WATCHDOG_EN
          else if (wd_cnt == WD_LAST) begin
            bus.start_tpu         <= 1'b0;
            bus.enable_matmul     <= 1'b0;
            bus.enable_norm       <= 1'b0;
            bus.enable_pool       <= 1'b0;
            bus.enable_activation <= 1'b0;
            bus.seq_busy          <= 1'b0;
            bus.seq_error         <= 1'b1;
            state                 <= S_ERR;
          end else begin
            bus.start_tpu <= 1'b1;
            wd_cnt        <= wd_cnt + 1'b1;
          end
`else
          else bus.start_tpu <= 1'b1;
`endif
        end
        // Control FSM must see done_tpu drop before the next start can rise.
        S_DRAIN: if (!bus.done_tpu) begin
          if ({1'b0, bus.layer_idx} == n_lat - 1'b1) begin
            bus.enable_matmul <= 1'b0;
            bus.seq_busy      <= 1'b0;
            bus.seq_done      <= 1'b1;
            state             <= S_DONE;
          end else begin
            bus.layer_idx <= bus.layer_idx + 1'b1;
            state         <= S_LOAD;
          end
        end
        S_DONE: if (!bus.seq_start) begin
          bus.seq_done <= 1'b0;
          state        <= S_IDLE;
        end
        S_ERR: if (!bus.seq_start) begin
          bus.seq_error <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tpu_layer_sequencer.sv
// Self-checking bench: vector table, hand sequences for corner cases, and random
// runs against a table-level model of the sequencer.
module tb_tpu_layer_sequencer;
  localparam int MAXL = 8;
  localparam int IW   = 3;
  localparam int AW   = 10;
  localparam int EW   = 3 + 3*AW;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tpu_layer_sequencer_if #(.IDX_W(IW), .ADDR_W(AW)) bus();

  tpu_layer_sequencer #(
    .MAX_LAYERS(MAXL), .IDX_W(IW), .ADDR_W(AW)
`ifdef SEQ_WATCHDOG_EN
    , .TIMEOUT_W(4)
`endif
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] cur_cfg();
    return {bus.enable_norm, bus.enable_pool, bus.enable_activation, bus.addr_a, bus.addr_b, bus.addr_c};
  endfunction

  function automatic logic [40:0] all_outs();
    return {bus.start_tpu, bus.enable_matmul, cur_cfg(), bus.layer_idx, bus.seq_busy, bus.seq_done, bus.seq_error};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Model of the table contents as the host believes them to be.
  logic [EW-1:0] mirror [MAXL];

  // Control FSM stand-in: raise done after resp_dly start cycles, drop it resp_hold cycles after start falls.
  bit resp_on = 1'b0;
  int resp_dly = 5;
  int resp_hold = 1;
  int last_fall = -1000;
  initial begin
    int cnt = 0;
    int hcnt = 0;
    bus.done_tpu = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!resp_on) begin
        bus.done_tpu = 1'b0; cnt = 0; hcnt = 0;
      end else if (!bus.done_tpu) begin
        if (bus.start_tpu) begin
          cnt++;
          if (cnt >= resp_dly) begin bus.done_tpu = 1'b1; cnt = 0; end
        end
      end else if (!bus.start_tpu) begin
        hcnt++;
        if (hcnt >= resp_hold) begin bus.done_tpu = 1'b0; hcnt = 0; last_fall = cyc; end
      end
    end
  end

  // Record every start pulse and check the handshake/config stability rules around it.
  typedef struct packed { logic [IW-1:0] idx; logic mm; logic [EW-1:0] cfg; } pulse_t;
  pulse_t pulse_q[$];
  initial begin
    logic prev = 1'b0;
    pulse_t rec;
    forever begin
      @(negedge clk);
      if (!reset && bus.start_tpu && !prev) begin
        rec = '{idx: bus.layer_idx, mm: bus.enable_matmul, cfg: cur_cfg()};
        pulse_q.push_back(rec);
        check("start_while_done", {63'd0, bus.done_tpu}, 64'd0);
        check("gap_after_done_fall", {63'd0, (cyc - last_fall) >= 2}, 64'd1);
      end else if (!reset && bus.start_tpu) begin
        check("cfg_stable_in_pulse", {31'd0, cur_cfg()}, {31'd0, rec.cfg});
      end
      prev = bus.start_tpu;
    end
  end

  task automatic write_entry(input int idx, input logic [EW-1:0] data);
    bus.cfg_wr_en = 1'b1; bus.cfg_wr_idx = IW'(idx); bus.cfg_wr_data = data;
    tick();
    bus.cfg_wr_en = 1'b0;
    mirror[idx] = data;
  endtask

  function automatic logic [EW-1:0] rand_entry();
    return {$urandom_range(0, 7), $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023)};
  endfunction

  task automatic run_seq(input int n, input bit e_done, input bit e_err, input int e_pulses,
                         input bit inject, input string tag);
    int k;
    pulse_q.delete();
    bus.num_layers = (IW+1)'(n);
    bus.seq_start  = 1'b1;
    k = 0;
    if (e_pulses > 0) begin
      do begin tick(); k++; end while (!bus.start_tpu && k < 10);
      check({tag, "_latency"}, 64'(k), 64'd3);
      if (inject) begin
        // Layer 0 is in flight: this write must be dropped.
        bus.cfg_wr_en = 1'b1; bus.cfg_wr_idx = 3'd1; bus.cfg_wr_data = ~mirror[1];
        tick();
        bus.cfg_wr_en = 1'b0;
      end
      k = 0;
    end
    while (!(bus.seq_done || bus.seq_error) && k < BUDGET) begin tick(); k++; end
    check({tag, "_in_budget"}, {63'd0, k < BUDGET}, 64'd1);
    if (e_pulses == 0) check({tag, "_fast_end"}, {63'd0, k <= 2}, 64'd1);
    check({tag, "_done"}, {63'd0, bus.seq_done}, {63'd0, e_done});
    check({tag, "_error"}, {63'd0, bus.seq_error}, {63'd0, e_err});
    check({tag, "_busy"}, {63'd0, bus.seq_busy}, 64'd0);
    check({tag, "_start_low"}, {63'd0, bus.start_tpu}, 64'd0);
    if (e_done) check({tag, "_mm_off"}, {63'd0, bus.enable_matmul}, 64'd0);
    check({tag, "_pulses"}, 64'(pulse_q.size()), 64'(e_pulses));
    for (int i = 0; i < e_pulses && i < pulse_q.size(); i++) begin
      check({tag, "_idx"}, 64'(pulse_q[i].idx), 64'(i));
      check({tag, "_mm"}, {63'd0, pulse_q[i].mm}, 64'd1);
      check({tag, "_cfg"}, {31'd0, pulse_q[i].cfg}, {31'd0, mirror[i]});
    end
    bus.seq_start = 1'b0;
    tick();
    check({tag, "_flags_clear"}, {62'd0, bus.seq_done, bus.seq_error}, 64'd0);
  endtask

  typedef struct { int n; bit e_done; bit e_err; int e_pulses; } vec_t;

  initial begin
    vec_t vecs[6];
    int k;
    int hi;
    int n;
    vecs[0] = '{3, 1'b1, 1'b0, 3};
    vecs[1] = '{0, 1'b1, 1'b0, 0};
    vecs[2] = '{9, 1'b0, 1'b1, 0};
    vecs[3] = '{8, 1'b1, 1'b0, 8};
    vecs[4] = '{1, 1'b1, 1'b0, 1};
    vecs[5] = '{15, 1'b0, 1'b1, 0};

    bus.seq_start = 1'b0; bus.num_layers = '0;
    bus.cfg_wr_en = 1'b0; bus.cfg_wr_idx = '0; bus.cfg_wr_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_outputs", {23'd0, all_outs()}, 64'd0);

    for (int i = 0; i < MAXL; i++) write_entry(i, rand_entry());
    resp_on = 1'b1;

    foreach (vecs[i]) run_seq(vecs[i].n, vecs[i].e_done, vecs[i].e_err, vecs[i].e_pulses, 1'b0, "vec");

    // Write to entry 1 while layer 0 runs: layer 1 must still see the old data.
    run_seq(2, 1'b1, 1'b0, 2, 1'b1, "midwrite");

    // done_tpu lingers 4 cycles after start drops; the monitor checks the restart gap.
    resp_hold = 4;
    run_seq(3, 1'b1, 1'b0, 3, 1'b0, "hold");
    resp_hold = 1;

    // Reset while a layer is running.
    bus.num_layers = 4'd4; bus.seq_start = 1'b1;
    k = 0;
    while (!bus.start_tpu && k < 20) begin tick(); k++; end
    check("rst_reached_run", {63'd0, bus.start_tpu}, 64'd1);
    reset = 1'b1; resp_on = 1'b0; bus.seq_start = 1'b0;
    tick();
    check("rst_mid_run", {23'd0, all_outs()}, 64'd0);
    reset = 1'b0; resp_on = 1'b1;
    tick();
    // Table survives reset.
    run_seq(4, 1'b1, 1'b0, 4, 1'b0, "post_rst");

`ifdef SEQ_WATCHDOG_EN
    resp_on = 1'b0;
    bus.num_layers = 4'd2; bus.seq_start = 1'b1;
    k = 0; hi = 0;
    while (!bus.seq_error && k < 300) begin tick(); k++; if (bus.start_tpu) hi++; end
    check("wd_error", {63'd0, bus.seq_error}, 64'd1);
    check("wd_start_cycles", 64'(hi), 64'd14);
    check("wd_start_low", {63'd0, bus.start_tpu}, 64'd0);
    check("wd_mm_off", {63'd0, bus.enable_matmul}, 64'd0);
    check("wd_idx", 64'(bus.layer_idx), 64'd0);
    bus.seq_start = 1'b0;
    tick();
    check("wd_error_clear", {63'd0, bus.seq_error}, 64'd0);
    resp_on = 1'b1;
`endif

    // Random table updates, lengths and handshake timing against the model rules.
    for (int it = 0; it < 16; it++) begin
      repeat ($urandom_range(0, 3)) write_entry($urandom_range(0, MAXL-1), rand_entry());
      n = $urandom_range(0, 12);
      resp_dly  = $urandom_range(1, 6);
      resp_hold = $urandom_range(1, 4);
      run_seq(n, n <= MAXL, n > MAXL, (n <= MAXL) ? n : 0, 1'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
